// File: rtl/cla_pipe_addsub_cla_block.sv
// rtl/cla_pipe_addsub_cla_block.sv - combinational W-bit carry-lookahead block
// Exposes the carry into the top bit so the caller can form signed overflow.
module cla_block #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c = {{W{1'b0}}, ci};
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s     = p ^ c[W-1:0];
  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined CLA adder/subtractor, one BLK-bit block per stage
// Global stall: every stage shifts together when the output slot is free or being taken.
module cla_pipe_addsub #(
  parameter int N   = 32,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int STAGES = N / BLK;

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k + 1) * BLK;

    logic [BLK-1:0] blk_a;
    logic [BLK-1:0] blk_b;
    logic [BLK-1:0] blk_s;
    logic           blk_ci;
    logic           blk_co;
    logic           v_d;
    logic [LO-1:0]  s_d;
    logic [LO-1:0]  s_q;
    logic           co_q;
    logic           v_q;

    // Stage 0 conditions the raw operands; later stages read the previous registers.
    if (k == 0) begin : g_in
      assign blk_a  = a[BLK-1:0];
      assign blk_b  = b[BLK-1:0] ^ {BLK{sub}};
      assign blk_ci = sub | cin;
      assign v_d    = in_valid;
      assign s_d    = blk_s;
    end else begin : g_in
      assign blk_a  = g_stage[k-1].g_fwd.a_q[BLK-1:0];
      assign blk_b  = g_stage[k-1].g_fwd.b_q[BLK-1:0];
      assign blk_ci = g_stage[k-1].co_q;
      assign v_d    = g_stage[k-1].v_q;
      assign s_d    = {blk_s, g_stage[k-1].s_q};
    end

    // Operand bits not yet consumed travel with the transaction.
    if (k < STAGES - 1) begin : g_fwd
      localparam int HI = N - LO;

      logic [HI-1:0] a_d;
      logic [HI-1:0] b_d;
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = a[N-1:BLK];
        assign b_d = b[N-1:BLK] ^ {HI{sub}};
      end else begin : g_src
        assign a_d = g_stage[k-1].g_fwd.a_q[HI+BLK-1:BLK];
        assign b_d = g_stage[k-1].g_fwd.b_q[HI+BLK-1:BLK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic blk_cmsb;
      logic ovf_q;
      logic zero_q;

      cla_block #(.W(BLK)) u_blk (
        .a     (blk_a),
        .b     (blk_b),
        .ci    (blk_ci),
        .s     (blk_s),
        .co    (blk_co),
        .c_msb (blk_cmsb)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= blk_co ^ blk_cmsb;
          zero_q <= (s_d == '0);
        end
      end
    end else begin : g_mid
      cla_block #(.W(BLK)) u_blk (
        .a     (blk_a),
        .b     (blk_b),
        .ci    (blk_ci),
        .s     (blk_s),
        .co    (blk_co),
        .c_msb ()
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q  <= '0;
        co_q <= 1'b0;
        v_q  <= 1'b0;
      end else if (advance) begin
        s_q  <= s_d;
        co_q <= blk_co;
        v_q  <= v_d;
      end
    end
  end

  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].co_q;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - randomized scoreboard bench for cla_pipe_addsub
// Two instances: N=32/BLK=8 (directed + random) and N=16/BLK=16 (random).
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n32, v32, r32, cin32, sub32, ov32, or32, co32, of32, z32;
  logic [31:0] a32, b32, sum32;
  logic        rst_n16, v16, r16, cin16, sub16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, sum16;

  logic [34:0] q32[$];
  logic [34:0] q16[$];
  logic [34:0] e32, e16;
  logic        done16 = 1'b0;

  cla_pipe_addsub #(.N(32), .BLK(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n32), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(co32), .ovf(of32), .zero(z32)
  );

  cla_pipe_addsub #(.N(16), .BLK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n16), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(co16), .ovf(of16), .zero(z16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on n-bit values; overflow = signed result out of range.
  function automatic logic [34:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint m, ua, ub, sa, sb, ures, sres;
    logic [31:0] s;
    logic co, ov;
    m  = longint'(1) << n;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(cin);
      sres = sa + sb + longint'(cin);
      co   = (ures >= m);
    end
    ov = (sres >= m / 2) || (sres < -(m / 2));
    s  = 32'(ures & (m - 1));
    return {co, ov, (s == 32'd0), s};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboards: retire outputs first, then record the accept seen on the same edge.
  always @(negedge clk) begin
    if (rst_n32) begin
      if (ov32 && or32) begin
        if (q32.size() == 0) check("d32_unexpected_out", 1, 0);
        else begin
          e32 = q32.pop_front();
          check("d32_result", {co32, of32, z32, sum32}, e32);
        end
      end
      if (v32 && r32) q32.push_back(model(32, a32, b32, cin32, sub32));
    end
    if (rst_n16) begin
      if (ov16 && or16) begin
        if (q16.size() == 0) check("d16_unexpected_out", 1, 0);
        else begin
          e16 = q16.pop_front();
          check("d16_result", {co16, of16, z16, 16'h0, sum16}, e16);
        end
      end
      if (v16 && r16) q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Directed rows: a, b, cin, sub, expected {cout, ovf, zero, sum}
  logic [31:0] ta [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h0000_00FF,
                          32'h00FF_FFFF, 32'h7FFF_FFFF, 32'h0000_0010, 32'h0000_0005};
  logic [31:0] tb [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001,
                          32'h0000_0000, 32'h0000_0001, 32'h0000_0003, 32'h0000_0005};
  logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [34:0] te [8] = '{{3'b101, 32'h0000_0000}, {3'b110, 32'h7FFF_FFFF},
                          {3'b000, 32'hFFFF_FFFE}, {3'b000, 32'h0000_0100},
                          {3'b000, 32'h0100_0000}, {3'b010, 32'h8000_0000},
                          {3'b100, 32'h0000_000D}, {3'b101, 32'h0000_0000}};

  initial begin
    int lat, cnt, runs, nacc, sent, guard;
    logic prev;
    logic [34:0] snap;
    rst_n32 = 1'b0; v32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    rst_n16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", ov32, 0);
    check("rst_sum", sum32, 0);
    check("rst_flags", {co32, of32, z32}, 0);
    check("rst_d16_out_valid", ov16, 0);
    rst_n32 = 1'b1; rst_n16 = 1'b1;
    #1;
    check("rst_in_ready", r32, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      a32 = ta[i]; b32 = tb[i]; cin32 = tc[i]; sub32 = ts[i]; v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      lat = 1;
      while (!ov32 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("dir%0d_latency", i), lat, 4);
      check($sformatf("dir%0d_value", i), {co32, of32, z32, sum32}, te[i]);
    end
    @(posedge clk); #1;

    cnt = 0; runs = 0; prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      v32 = (i < 8); a32 = pick32(); b32 = pick32();
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i < 8) check("b2b_in_ready", r32, 1);
      if (ov32) cnt++;
      if (ov32 && !prev) runs++;
      prev = ov32;
      @(posedge clk); #1;
    end
    check("b2b_out_count", cnt, 8);
    check("b2b_out_runs", runs, 1);

    or32 = 1'b0; nacc = 0;
    for (int i = 0; i < 10; i++) begin
      v32 = 1'b1; a32 = pick32(); b32 = pick32();
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!r32) break;
      nacc++;
      @(posedge clk); #1;
    end
    v32 = 1'b0;
    check("stall_fill", nacc, 4);
    snap = {co32, of32, z32, sum32};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_in_ready", r32, 0);
      check("stall_out_valid", ov32, 1);
      check("stall_hold", {co32, of32, z32, sum32}, snap);
    end
    @(posedge clk); #1;
    or32 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("stall_drain", q32.size(), 0);

    or32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v32 = 1'b1; a32 = pick32(); b32 = pick32();
      @(posedge clk); #1;
    end
    v32 = 1'b0;
    check("midrst_pre_valid", ov32, 1);
    #2;
    rst_n32 = 1'b0;
    #1;
    check("midrst_out_valid", ov32, 0);
    check("midrst_sum", sum32, 0);
    q32.delete();
    @(posedge clk); #1;
    rst_n32 = 1'b1; or32 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov32) cnt++;
    end
    check("midrst_no_stale", cnt, 0);
    @(posedge clk); #1;

    sent = 0;
    while (sent < 10000) begin
      a32 = pick32(); b32 = pick32();
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      v32 = ($urandom_range(0, 4) != 0); or32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v32 && r32) sent++;
      @(posedge clk); #1;
    end
    v32 = 1'b0; or32 = 1'b1;
    guard = 0;
    while (q32.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("d32_drain", q32.size(), 0);

    guard = 0;
    while (!done16 && guard < 100000) begin
      @(posedge clk);
      guard++;
    end
    check("d16_done", done16, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int sent, guard;
    logic [31:0] t;
    v16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge rst_n16);
    @(posedge clk); #1;
    sent = 0;
    while (sent < 10000) begin
      t = pick32(); a16 = $urandom_range(0, 1) ? t[31:16] : t[15:0];
      t = pick32(); b16 = $urandom_range(0, 1) ? t[31:16] : t[15:0];
      cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      v16 = ($urandom_range(0, 4) != 0); or16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v16 && r16) sent++;
      @(posedge clk); #1;
    end
    v16 = 1'b0; or16 = 1'b1;
    guard = 0;
    while (q16.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("d16_drain", q16.size(), 0);
    done16 = 1'b1;
  end

endmodule
